knn_rom_reader: RTL and testbench
=================================

Name: knn_rom_reader

Overview:
- Read-side sequencer for the single-port KNN training-vector BRAM. The BRAM has a 1-cycle registered read; read enable is `r`, write enable is `w`, and a write is only honoured while `r` is high.
- On `start`, the block streams an inclusive address range out of the BRAM as a valid/ready stream of RAM_WIDTH-bit words, with each word's address attached.
- It feeds the distance-computation stage and sustains 1 word/clk under full downstream readiness.

Parameters:
- RAM_WIDTH, 256, width of one stored training vector (BRAM word).
- RAM_ADDR_BITS, 9, BRAM address width.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  launch request; sampled only in IDLE.
- start_addr  in  RAM_ADDR_BITS  first address, latched on accepted start.
- end_addr  in  RAM_ADDR_BITS  last address (inclusive), latched on accepted start.
- bram_r  out  1  BRAM read enable, drives BRAM `r`.
- bram_w  out  1  BRAM write enable, constant 0.
- bram_addr  out  RAM_ADDR_BITS  BRAM address.
- bram_dataIn  out  RAM_WIDTH  BRAM write data, constant 0.
- bram_dataOut  in  RAM_WIDTH  BRAM read data, valid the cycle after bram_r=1.
- m_valid  out  1  output word valid.
- m_ready  in  1  downstream accept.
- m_data  out  RAM_WIDTH  output word.
- m_index  out  RAM_ADDR_BITS  address m_data was read from.
- m_last  out  1  high with the word from end_addr.
- busy  out  1  high from accepted start until done.
- done  out  1  1-cycle pulse at end of run.
- err  out  1  1-cycle pulse, coincident with done, on empty/illegal range.

Behaviour:
- Reset: when rst_n=0 at a clock edge, all state and outputs go to 0 at that edge: bram_r, bram_addr, m_valid, m_data, m_index, m_last, busy, done, err. State returns to IDLE. Any in-flight read and any buffered words are discarded. This applies at any point mid-run.
- States:
  - IDLE: waiting for start.
  - ISSUE: issuing reads; buffered words may also be draining.
  - DRAIN: all reads issued; waiting for the buffer to empty.
  - FIN: one cycle; done=1, busy=0.
- IDLE, start=1, start_addr<=end_addr: latch the range, busy=1 next cycle, go to ISSUE.
- IDLE, start=1, start_addr>end_addr: next cycle done=1 and err=1 for one cycle, busy stays 0, no BRAM access, remain in IDLE.
- start while not IDLE: ignored. The latched range is unaffected.
- Read issue: bram_r=1 with bram_addr=A. Word A is captured from bram_dataOut on the following edge into a 2-entry output buffer; m_data/m_valid are driven from the buffer head.
- Issue rule: a read may be issued only if (buffered words − pop this cycle + reads in flight) < 2. No word is ever dropped, duplicated or reordered.
- Throughput: with m_ready=1 throughout, one word per clk.
- Latency: start accepted at edge T → first bram_r at cycle T+1 → first m_valid at cycle T+3.
- bram_r=0 whenever no read is issued. bram_addr holds its last value.
- Address increments by 1 per issued read. After issuing end_addr, go to DRAIN.
- Range end_addr=2^RAM_ADDR_BITS−1 is legal: the address counter must not wrap and re-read 0. Use an explicit last-issued flag, not a counter compare after increment.
- Stream handshake:
  - A transfer occurs when m_valid&m_ready.
  - While m_valid=1 and m_ready=0: m_data, m_index and m_last hold stable and m_valid stays 1.
  - m_valid never depends combinationally on m_ready.
- m_last=1 exactly on the word whose m_index=end_addr.
- Single-word range (start_addr==end_addr): one transfer with m_last=1.
- DRAIN → FIN after the transfer carrying m_last. In FIN, done=1 for one cycle and busy=0 in that same cycle, then go to IDLE.
- start asserted in the FIN cycle is ignored. start in the cycle after FIN is accepted.
- bram_w=0 and bram_dataIn=0 at all times; the block never writes the BRAM.

Test Plan:
- Reset, then start with start_addr=0, end_addr=299, m_ready=1, BRAM preloaded word[i]=i → 300 transfers, m_index 0..299 in order, m_data=i, m_last only at 299, first m_valid 3 cycles after start, done pulse after the last transfer.
- Same run with m_ready random at 50% → same 300 words in order; m_data/m_index stable while stalled; bram_r never issued when the buffer plus in-flight reads equal 2.
- Range 7..7 → exactly one transfer with m_index=7 and m_last=1; done pulses once; busy high for the run only.
- start_addr=10, end_addr=5 → done=1 and err=1 for one cycle, bram_r never asserted, m_valid stays 0.
- Range 510..511 with RAM_ADDR_BITS=9 → exactly 2 words (510 then 511), no read of address 0.
- Run 0..299, pull rst_n low at word 100 for one cycle → all outputs 0 on the next edge. A new start 20..21 then yields exactly words 20 and 21; no stale data from the aborted run appears.

Source files
------------

// File: rtl/knn_rom_reader.sv
// knn_rom_reader: streams an inclusive address range out of the single-port
// KNN training-vector BRAM as a valid/ready stream, one word per clock when
// the consumer is always ready. Reads are issued only when the 2-entry
// output buffer is guaranteed to have room for the returning word.
module knn_rom_reader #(
    parameter int RAM_WIDTH     = 256,
    parameter int RAM_ADDR_BITS = 9
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [RAM_ADDR_BITS-1:0] start_addr,
    input  logic [RAM_ADDR_BITS-1:0] end_addr,
    output logic                     bram_r,
    output logic                     bram_w,
    output logic [RAM_ADDR_BITS-1:0] bram_addr,
    output logic [RAM_WIDTH-1:0]     bram_dataIn,
    input  logic [RAM_WIDTH-1:0]     bram_dataOut,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [RAM_WIDTH-1:0]     m_data,
    output logic [RAM_ADDR_BITS-1:0] m_index,
    output logic                     m_last,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    localparam logic [RAM_ADDR_BITS-1:0] ADDR_ONE = RAM_ADDR_BITS'(1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_FIN} state_t;

    typedef struct packed {
        logic [RAM_WIDTH-1:0]     data;
        logic [RAM_ADDR_BITS-1:0] index;
        logic                     last;
    } entry_t;

    state_t                     r_state;
    state_t                     w_next_state;
    logic [RAM_ADDR_BITS-1:0]   r_next_addr;     // next address to read
    logic [RAM_ADDR_BITS-1:0]   r_end_addr;
    logic [RAM_ADDR_BITS-1:0]   r_last_addr;     // last address put on the bus
    logic                       r_inflight;      // read issued last cycle, data on bram_dataOut now
    logic [RAM_ADDR_BITS-1:0]   r_inflight_addr;
    logic                       r_inflight_last;
    entry_t                     r_buf0;          // buffer head, drives the stream
    entry_t                     r_buf1;
    logic [1:0]                 r_count;
    logic                       r_err;

    logic                       w_pop;
    logic                       w_issue;
    logic                       w_issue_last;
    logic                       w_start_ok;
    logic                       w_start_bad;
    logic                       w_slot0;
    logic [2:0]                 w_occupancy;
    entry_t                     w_new;

    assign w_start_ok   = (r_state == S_IDLE) && start && (start_addr <= end_addr);
    assign w_start_bad  = (r_state == S_IDLE) && start && (start_addr > end_addr);
    assign w_pop        = m_valid && m_ready;
    // Buffered words after this cycle's pop, plus the word arriving from the BRAM.
    assign w_occupancy  = {1'b0, r_count} + {2'b0, r_inflight} - {2'b0, w_pop};
    assign w_issue      = (r_state == S_ISSUE) && (w_occupancy < 3'd2);
    // The last-issued decision comes from the current address, so end_addr = all-ones never wraps.
    assign w_issue_last = w_issue && (r_next_addr == r_end_addr);
    // Returning word lands in the head slot when the buffer is empty after the pop.
    assign w_slot0      = (r_count == 2'd0) || ((r_count == 2'd1) && w_pop);
    assign w_new        = {bram_dataOut, r_inflight_addr, r_inflight_last};

    assign m_valid      = (r_count != 2'd0);
    assign m_data       = r_buf0.data;
    assign m_index      = r_buf0.index;
    assign m_last       = r_buf0.last;
    assign bram_w       = 1'b0;
    assign bram_dataIn  = '0;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default assignment first so every path drives the signal and no latch is inferred.
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_start_ok) w_next_state = S_ISSUE;
            S_ISSUE: if (w_issue_last) w_next_state = S_DRAIN;
            S_DRAIN: if (w_pop && r_buf0.last) w_next_state = S_FIN;
            S_FIN:   w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // State-decoded outputs; the BRAM address holds its last value between reads.
    always_comb begin
        busy      = (r_state == S_ISSUE) || (r_state == S_DRAIN);
        done      = (r_state == S_FIN) || r_err;
        err       = r_err;
        bram_r    = w_issue;
        bram_addr = w_issue ? r_next_addr : r_last_addr;
    end

    // Range latch, address counter, read pipeline and output buffer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the buffer is reset too, because m_data/m_index/m_last must read 0 after reset.
            r_next_addr     <= '0;
            r_end_addr      <= '0;
            r_last_addr     <= '0;
            r_inflight      <= 1'b0;
            r_inflight_addr <= '0;
            r_inflight_last <= 1'b0;
            r_buf0          <= '0;
            r_buf1          <= '0;
            r_count         <= 2'd0;
            r_err           <= 1'b0;
        end else begin
            r_err <= w_start_bad;

            if (w_start_ok) begin
                r_next_addr <= start_addr;
                r_end_addr  <= end_addr;
            end else if (w_issue && !w_issue_last) begin
                r_next_addr <= r_next_addr + ADDR_ONE;
            end

            r_inflight <= w_issue;
            if (w_issue) begin
                r_last_addr     <= r_next_addr;
                r_inflight_addr <= r_next_addr;
                r_inflight_last <= w_issue_last;
            end

            // NOTE: non-blocking assignments let a later write to r_buf0 override the shift in the same cycle.
            if (w_pop) begin
                r_buf0 <= r_buf1;
            end
            if (r_inflight) begin
                if (w_slot0) begin
                    r_buf0 <= w_new;
                end else begin
                    r_buf1 <= w_new;
                end
            end

            r_count <= w_occupancy[1:0];
        end
    end

endmodule

// File: tb/tb_knn_rom_reader.sv
// Bench for knn_rom_reader: BRAM model with registered read, an expected-word
// queue built from the requested range, and one negedge compare process.
module tb_knn_rom_reader;

    localparam int W     = 256;
    localparam int AW    = 9;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic [AW-1:0] end_addr = '0;
    logic          bram_r;
    logic          bram_w;
    logic [AW-1:0] bram_addr;
    logic [W-1:0]  bram_dataIn;
    logic [W-1:0]  bram_dataOut = '0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [W-1:0]  m_data;
    logic [AW-1:0] m_index;
    logic          m_last;
    logic          busy;
    logic          done;
    logic          err;

    always #5 clk = ~clk;

    knn_rom_reader #(.RAM_WIDTH(W), .RAM_ADDR_BITS(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr), .end_addr(end_addr),
        .bram_r(bram_r), .bram_w(bram_w), .bram_addr(bram_addr), .bram_dataIn(bram_dataIn),
        .bram_dataOut(bram_dataOut), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_index(m_index), .m_last(m_last), .busy(busy), .done(done), .err(err)
    );

    // BRAM model: registered read while r is high.
    logic [W-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (bram_r) bram_dataOut <= mem[bram_addr];
    end

    // Downstream readiness, changed just after each rising edge.
    int ready_pct = 100;
    always @(posedge clk) begin
        #1;
        m_ready = ($urandom_range(99) < ready_pct);
    end

    typedef struct {
        int unsigned  index;
        logic [W-1:0] data;
        bit           last;
    } word_t;

    word_t       exp_q[$];
    int unsigned iss_q[$];
    int          checks = 0;
    int          errors = 0;
    int          xfer_cnt = 0;
    int          done_cnt = 0;
    int          err_cnt = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input int val);
        checks++;
        errors++;
        $display("FAIL %s: value %0d", name, val);
    endtask

    // Model: every address of a legal range is read once, in order, last flagged on end.
    task automatic expect_range(input int s, input int e);
        for (int a = s; a <= e; a++) begin
            word_t w;
            w.index = a;
            w.data  = mem[a];
            w.last  = (a == e);
            exp_q.push_back(w);
            iss_q.push_back(a);
        end
    endtask

    // Compare process: stream contents, stall stability, issue addresses and room.
    int           outstanding = 0;
    bit           stalled = 0;
    logic [W-1:0] st_data;
    logic [AW-1:0] st_index;
    logic         st_last;
    always @(negedge clk) begin : cmp
        word_t w;
        bit    pop;
        bit    room_ok;
        if (!rst_n) begin
            outstanding = 0;
            stalled = 0;
            exp_q.delete();
            iss_q.delete();
        end else begin
            pop = m_valid && m_ready;
            check("bram_w", W'(bram_w), '0);
            check("bram_dataIn", bram_dataIn, '0);
            if (bram_r) begin
                if (iss_q.size() == 0) fail_now("unexpected_issue_addr", int'(bram_addr));
                else check("issue_addr", W'(bram_addr), W'(iss_q.pop_front()));
                room_ok = (outstanding - int'(pop)) < 2;
                check("issue_room", W'(room_ok), W'(1));
            end
            if (stalled) begin
                check("stall_valid", W'(m_valid), W'(1));
                check("stall_data", m_data, st_data);
                check("stall_index", W'(m_index), W'(st_index));
                check("stall_last", W'(m_last), W'(st_last));
            end
            if (pop) begin
                xfer_cnt++;
                if (exp_q.size() == 0) fail_now("unexpected_word_index", int'(m_index));
                else begin
                    w = exp_q.pop_front();
                    check("xfer_index", W'(m_index), W'(w.index));
                    check("xfer_data", m_data, w.data);
                    check("xfer_last", W'(m_last), W'(w.last));
                end
            end
            stalled  = m_valid && !m_ready;
            st_data  = m_data;
            st_index = m_index;
            st_last  = m_last;
            outstanding += int'(bram_r) - int'(pop);
            if (done) done_cnt++;
            if (err) err_cnt++;
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_bram_r"}, W'(bram_r), '0);
        check({tag, "_bram_addr"}, W'(bram_addr), '0);
        check({tag, "_m_valid"}, W'(m_valid), '0);
        check({tag, "_m_data"}, m_data, '0);
        check({tag, "_m_index"}, W'(m_index), '0);
        check({tag, "_m_last"}, W'(m_last), '0);
        check({tag, "_busy"}, W'(busy), '0);
        check({tag, "_done"}, W'(done), '0);
        check({tag, "_err"}, W'(err), '0);
    endtask

    // Returns just after the edge that samples start.
    task automatic pulse_start(input int s, input int e);
        @(posedge clk);
        #1;
        start = 1'b1;
        start_addr = AW'(s);
        end_addr = AW'(e);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit exp_err);
        bit found = 0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (done) begin
                found = 1;
                break;
            end
        end
        if (!found) fail_now("done_timeout", budget);
        else begin
            check("done_busy", W'(busy), '0);
            check("done_err", W'(err), W'(exp_err));
            check("done_words_left", W'(exp_q.size()), '0);
            @(negedge clk);
            check("done_pulse_width", W'(done), '0);
        end
    endtask

    task automatic run_range(input int s, input int e, input int budget);
        int xb = xfer_cnt;
        int db = done_cnt;
        expect_range(s, e);
        pulse_start(s, e);
        check("run_busy", W'(busy), W'(1));
        wait_done(budget, 1'b0);
        check("run_xfers", W'(xfer_cnt - xb), W'(e - s + 1));
        check("run_done_count", W'(done_cnt - db), W'(1));
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int xb;
        int db;
        int eb;
        bit reached;
        for (int i = 0; i < DEPTH; i++) mem[i] = W'(i);

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;

        // Pin the model on hand-known values.
        expect_range(0, 299);
        check("model_size", W'(exp_q.size()), W'(300));
        check("model_first_index", W'(exp_q[0].index), W'(0));
        check("model_word123", exp_q[123].data, W'(123));
        check("model_last_299", W'(exp_q[299].last), W'(1));
        check("model_last_298", W'(exp_q[298].last), W'(0));

        // Full-rate run 0..299 with latency checks.
        ready_pct = 100;
        xb = xfer_cnt;
        db = done_cnt;
        pulse_start(0, 299);
        @(negedge clk);
        check("lat_busy", W'(busy), W'(1));
        check("lat_bram_r", W'(bram_r), W'(1));
        check("lat_bram_addr", W'(bram_addr), W'(0));
        check("lat_valid_c1", W'(m_valid), '0);
        @(negedge clk);
        check("lat_valid_c2", W'(m_valid), '0);
        @(negedge clk);
        check("lat_valid_c3", W'(m_valid), W'(1));
        check("lat_first_index", W'(m_index), W'(0));
        check("lat_first_data", m_data, W'(0));
        wait_done(1000, 1'b0);
        check("full_xfers", W'(xfer_cnt - xb), W'(300));
        check("full_done_count", W'(done_cnt - db), W'(1));

        // Random data, 50% readiness, with an ignored start mid-run.
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        end
        ready_pct = 50;
        xb = xfer_cnt;
        expect_range(0, 299);
        pulse_start(0, 299);
        repeat (20) @(posedge clk);
        pulse_start(3, 4);
        wait_done(3000, 1'b0);
        check("rand_xfers", W'(xfer_cnt - xb), W'(300));

        // Single-word range.
        run_range(7, 7, 200);
        @(negedge clk);
        check("single_busy_after", W'(busy), '0);

        // Illegal range: error pulse, no BRAM access, no stream.
        db = done_cnt;
        eb = err_cnt;
        pulse_start(10, 5);
        check("illegal_done", W'(done), W'(1));
        check("illegal_err", W'(err), W'(1));
        check("illegal_busy", W'(busy), '0);
        check("illegal_valid", W'(m_valid), '0);
        @(posedge clk);
        #1;
        check("illegal_done_clear", W'(done), '0);
        check("illegal_err_clear", W'(err), '0);
        repeat (5) @(posedge clk);
        check("illegal_done_count", W'(done_cnt - db), W'(1));
        check("illegal_err_count", W'(err_cnt - eb), W'(1));

        // Top-of-memory range must not wrap to address 0.
        run_range(510, 511, 200);
        repeat (5) @(posedge clk);

        // Reset in the middle of a run, then a clean short run.
        ready_pct = 100;
        xb = xfer_cnt;
        expect_range(0, 299);
        pulse_start(0, 299);
        reached = 0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (xfer_cnt - xb >= 100) begin
                reached = 1;
                break;
            end
        end
        if (!reached) fail_now("midrun_timeout", xfer_cnt - xb);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_all_zero("midrun");
        rst_n = 1'b1;
        ready_pct = 50;
        run_range(20, 21, 200);
        repeat (5) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
